// File: rtl/instruction_fetch_sequencer_if.sv
// Handshake/bus bundle between the fetch sequencer, program ROM and decoder.
interface instruction_fetch_sequencer_if #(
    parameter int unsigned PC_W = 8
);
    // Run control
    logic            run;
    logic            step;
    // Program ROM port
    logic            rom_rd;
    logic [PC_W-1:0] rom_addr;
    logic [10:0]     rom_data;
    logic            rom_valid;
    // Decoder instruction channel
    logic [4:0]      op;
    logic [2:0]      lr;
    logic [2:0]      sr;
    logic            instr_valid;
    logic            instr_ready;
    // Decoder PC feedback
    logic            pc_nld;
    logic            skip;
    logic [PC_W-1:0] jump_addr;
    // Status
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            fetch_err;

    // Sequencer side
    modport master (
        input  run, step, rom_data, rom_valid, instr_ready, pc_nld, skip, jump_addr,
        output rom_rd, rom_addr, op, lr, sr, instr_valid, pc, busy, fetch_err
    );

    // Environment side (ROM, decoder, run control)
    modport slave (
        output run, step, rom_data, rom_valid, instr_ready, pc_nld, skip, jump_addr,
        input  rom_rd, rom_addr, op, lr, sr, instr_valid, pc, busy, fetch_err
    );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: holds the PC, reads program ROM, issues OP/LR/SR to the
// decoder over valid/ready and updates the PC from jump/skip feedback at accept.
module instruction_fetch_sequencer #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input logic                           clk,
    input logic                           rst,
    instruction_fetch_sequencer_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             rom_rd_q, rom_rd_d;
    logic [PC_W-1:0]  rom_addr_q, rom_addr_d;
    logic [4:0]       op_q, op_d;
    logic [2:0]       lr_q, lr_d;
    logic [2:0]       sr_q, sr_d;
    logic             instr_valid_q, instr_valid_d;
    logic             fetch_err_q, fetch_err_d;
    logic             step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            rom_rd_q      <= 1'b0;
            rom_addr_q    <= '0;
            op_q          <= '0;
            lr_q          <= '0;
            sr_q          <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            step_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rom_rd_q      <= rom_rd_d;
            rom_addr_q    <= rom_addr_d;
            op_q          <= op_d;
            lr_q          <= lr_d;
            sr_q          <= sr_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            step_q        <= step_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state, PC update and registered-output decode
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rom_rd_d      = 1'b0;
        rom_addr_d    = rom_addr_q;
        op_d          = op_q;
        lr_d          = lr_q;
        sr_d          = sr_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        cnt_d         = cnt_q;
        // STEP is only meaningful in stepped mode; repeated pulses collapse into one
        step_d        = step_q | (bus.step & ~bus.run);

        unique case (state_q)
            S_IDLE: begin
                if (bus.run || step_q) begin
                    state_d = S_FETCH;
                    step_d  = bus.step & ~bus.run;
                end
            end
            S_FETCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.rom_valid) begin
                    op_d          = bus.rom_data[10:6];
                    lr_d          = bus.rom_data[5:3];
                    sr_d          = bus.rom_data[2:0];
                    instr_valid_d = 1'b1;
                    state_d       = S_ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    // Jump has priority over skip; arithmetic wraps at 2^PC_W
                    if (!bus.pc_nld) begin
                        pc_d = bus.jump_addr;
                    end else if (bus.skip) begin
                        pc_d = pc_q + PC_W'(2);
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                    state_d = bus.run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read strobe and address are registered so they line up with the FETCH cycle
        if (state_d == S_FETCH) begin
            rom_rd_d   = 1'b1;
            rom_addr_d = pc_d;
        end
    end

    assign bus.rom_rd      = rom_rd_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.op          = op_q;
    assign bus.lr          = lr_q;
    assign bus.sr          = sr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.fetch_err   = fetch_err_q;
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Self-checking bench for instruction_fetch_sequencer: directed sequences, a PC-update
// vector table, and randomized traffic checked by a transaction-level program model.
module tb_instruction_fetch_sequencer;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instruction_fetch_sequencer_if #(.PC_W(PC_W)) bus();

    instruction_fetch_sequencer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] start_pc;
        logic       nld;
        logic       skip;
        logic [7:0] jump;
        logic [7:0] exp_pc;
        string      name;
    } pc_vec_t;

    int         n_cmp   = 0;
    int         n_fail  = 0;
    int         rd_cnt  = 0;
    int         acc_cnt = 0;
    int         model_pc = 0;
    int         rom_lat = 1;
    int         pend_cnt = 0;
    logic [7:0] pend_addr = '0;
    logic       prev_rd = 1'b0;
    logic [10:0] rom [256];
    pc_vec_t    tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) at negedges for instr_valid (which=0) or rom_rd (which=1)
    task automatic wait_for(input int which, input string name);
        int n;
        n = 0;
        while (n < 200 && !((which == 0) ? bus.instr_valid : bus.rom_rd)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: timed out after %0d cycles, expected event", name, n);
        end
    endtask

    task automatic accept(input logic nld, input logic skp, input logic [7:0] jmp);
        bus.instr_ready = 1'b1;
        bus.pc_nld      = nld;
        bus.skip        = skp;
        bus.jump_addr   = jmp;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.pc_nld      = 1'b1;
        bus.skip        = 1'b0;
    endtask

    task automatic pulse_step();
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
    endtask

    // ROM model: answers a read rom_lat cycles later (0 = never answers)
    always @(negedge clk) begin
        bus.rom_valid = 1'b0;
        bus.rom_data  = 11'($urandom);
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                bus.rom_valid = 1'b1;
                bus.rom_data  = rom[pend_addr];
            end
        end
        if (bus.rom_rd && rom_lat > 0) begin
            pend_cnt  = rom_lat;
            pend_addr = bus.rom_addr;
        end
    end

    // Program-level reference: every read must target the model PC, every accepted
    // instruction must be the ROM word at the model PC, then PC follows jump/skip/inc
    always @(posedge clk) begin
        if (rst) begin
            model_pc = 0;
            prev_rd  = 1'b0;
        end else begin
            if (bus.rom_rd) begin
                rd_cnt++;
                check("rd_addr", 32'(bus.rom_addr), 32'(model_pc));
                check("rd_single_cycle", 32'(prev_rd), 32'(0));
            end
            prev_rd = bus.rom_rd;
            if (bus.instr_valid && bus.instr_ready) begin
                acc_cnt++;
                check("acc_fields", 32'({bus.op, bus.lr, bus.sr}), 32'(rom[model_pc]));
                check("acc_pc", 32'(bus.pc), 32'(model_pc));
                if (!bus.pc_nld)   model_pc = int'(bus.jump_addr);
                else if (bus.skip) model_pc = (model_pc + 2) % 256;
                else               model_pc = (model_pc + 1) % 256;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int cyc;
        int r0;
        int a0;

        for (int i = 0; i < 256; i++) rom[i] = 11'($urandom);
        rom[0] = 11'h5A3;
        rom[1] = 11'h012;

        tbl[0] = '{8'h10, 1'b0, 1'b1, 8'h40, 8'h40, "jump_beats_skip"};
        tbl[1] = '{8'h10, 1'b1, 1'b1, 8'h40, 8'h12, "skip"};
        tbl[2] = '{8'h10, 1'b1, 1'b0, 8'h40, 8'h11, "inc"};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 8'h00, 8'h01, "skip_wrap"};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 8'h00, 8'h00, "inc_wrap"};
        tbl[5] = '{8'hFE, 1'b1, 1'b1, 8'h33, 8'h00, "skip_wrap_fe"};
        tbl[6] = '{8'h80, 1'b0, 1'b0, 8'h7F, 8'h7F, "jump_noskip"};

        bus.run         = 1'b0;
        bus.step        = 1'b0;
        bus.instr_ready = 1'b0;
        bus.pc_nld      = 1'b1;
        bus.skip        = 1'b0;
        bus.jump_addr   = '0;
        bus.rom_valid   = 1'b0;
        bus.rom_data    = '0;

        // Reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rom_rd", 32'(bus.rom_rd), 0);
        check("rst_rom_addr", 32'(bus.rom_addr), 0);
        check("rst_fields", 32'({bus.op, bus.lr, bus.sr}), 0);
        check("rst_instr_valid", 32'(bus.instr_valid), 0);
        check("rst_pc", 32'(bus.pc), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_fetch_err", 32'(bus.fetch_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Free run from reset, ROM latency 1, decoder always ready
        bus.instr_ready = 1'b1;
        bus.run = 1'b1;
        cyc = 0;
        while (!bus.instr_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_to_valid_latency", 32'(cyc), 3);
        check("t1_i0_fields", 32'({bus.op, bus.lr, bus.sr}), 32'({5'h16, 3'd4, 3'd3}));
        check("t1_i0_pc", 32'(bus.pc), 0);
        @(negedge clk);
        check("t1_pc_after_i0", 32'(bus.pc), 1);
        wait_for(0, "t1_i1_valid");
        check("t1_i1_fields", 32'({bus.op, bus.lr, bus.sr}), 32'({5'h00, 3'd2, 3'd2}));
        check("t1_i1_pc", 32'(bus.pc), 1);
        @(negedge clk);
        check("t1_pc_after_i1", 32'(bus.pc), 2);
        bus.run = 1'b0;
        repeat (10) @(negedge clk);
        check("t1_idle_busy", 32'(bus.busy), 0);

        // PC update vectors: jump to start_pc, then accept with the vector's feedback
        bus.instr_ready = 1'b0;
        bus.run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_for(0, "tbl_valid_a");
            accept(1'b0, 1'b0, tbl[i].start_pc);
            wait_for(0, "tbl_valid_b");
            check($sformatf("%s_start_pc", tbl[i].name), 32'(bus.pc), 32'(tbl[i].start_pc));
            accept(tbl[i].nld, tbl[i].skip, tbl[i].jump);
            check($sformatf("%s_rd", tbl[i].name), 32'(bus.rom_rd), 1);
            check($sformatf("%s_addr", tbl[i].name), 32'(bus.rom_addr), 32'(tbl[i].exp_pc));
            check($sformatf("%s_pc", tbl[i].name), 32'(bus.pc), 32'(tbl[i].exp_pc));
        end
        bus.run = 1'b0;
        wait_for(0, "tbl_drain");
        accept(1'b1, 1'b0, 8'h00);
        repeat (5) @(negedge clk);
        check("tbl_idle_busy", 32'(bus.busy), 0);

        // Single-step: two pulses while an instruction is held count as one
        pulse_step();
        wait_for(0, "step_first_valid");
        r0 = rd_cnt;
        a0 = acc_cnt;
        pulse_step();
        @(negedge clk);
        pulse_step();
        bus.instr_ready = 1'b1;
        repeat (30) @(negedge clk);
        bus.instr_ready = 1'b0;
        check("step_double_rd", 32'(rd_cnt - r0), 1);
        check("step_double_acc", 32'(acc_cnt - a0), 2);
        check("step_double_busy", 32'(bus.busy), 0);
        r0 = rd_cnt;
        a0 = acc_cnt;
        pulse_step();
        wait_for(0, "step_again_valid");
        accept(1'b1, 1'b0, 8'h00);
        repeat (10) @(negedge clk);
        check("step_again_rd", 32'(rd_cnt - r0), 1);
        check("step_again_acc", 32'(acc_cnt - a0), 1);

        // STEP while RUN=1 must not be latched
        bus.run = 1'b1;
        wait_for(0, "step_run_valid");
        r0 = rd_cnt;
        pulse_step();
        bus.run = 1'b0;
        accept(1'b1, 1'b0, 8'h00);
        repeat (20) @(negedge clk);
        check("step_ignored_in_run", 32'(rd_cnt - r0), 0);

        // Randomized traffic against the program model
        a0 = acc_cnt;
        for (int i = 0; i < 2000; i++) begin
            bus.run         = ($urandom_range(0, 9) != 0);
            bus.step        = ($urandom_range(0, 19) == 0);
            bus.instr_ready = 1'($urandom_range(0, 1));
            bus.pc_nld      = ($urandom_range(0, 4) != 0);
            bus.skip        = ($urandom_range(0, 2) == 0);
            bus.jump_addr   = 8'($urandom);
            rom_lat         = ($urandom_range(0, 31) == 0) ? 16 : $urandom_range(1, 6);
            @(negedge clk);
        end
        bus.run = 1'b0;
        bus.step = 1'b0;
        bus.instr_ready = 1'b1;
        bus.pc_nld = 1'b1;
        bus.skip = 1'b0;
        rom_lat = 1;
        repeat (60) @(negedge clk);
        bus.instr_ready = 1'b0;
        check("rand_progress", 32'(acc_cnt - a0 > 100), 1);
        check("rand_idle_busy", 32'(bus.busy), 0);
        check("rand_no_err", 32'(bus.fetch_err), 0);

        // Reset while waiting on the ROM; the late answer must be ignored
        rom_lat = 5;
        pulse_step();
        wait_for(1, "rstwait_rd");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstwait_pc", 32'(bus.pc), 0);
        check("rstwait_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rstwait_no_issue", 32'({bus.instr_valid, bus.rom_rd}), 0);
        end
        rom_lat = 1;
        bus.run = 1'b1;
        wait_for(1, "restart_rd");
        check("restart_addr", 32'(bus.rom_addr), 0);
        wait_for(0, "restart_valid");
        for (int i = 0; i < 10; i++) begin
            check("hold_fields", 32'({bus.instr_valid, bus.op, bus.lr, bus.sr}),
                  32'({1'b1, rom[0]}));
            @(negedge clk);
        end
        bus.run = 1'b0;
        accept(1'b1, 1'b0, 8'h00);
        repeat (5) @(negedge clk);

        // ROM latency exactly TIMEOUT is still accepted
        rom_lat = TIMEOUT;
        pulse_step();
        wait_for(0, "lat_max_valid");
        check("lat_max_no_err", 32'(bus.fetch_err), 0);
        accept(1'b1, 1'b0, 8'h00);
        repeat (5) @(negedge clk);

        // ROM never answers: fetch error and halt exactly after TIMEOUT wait cycles
        rom_lat = 0;
        pulse_step();
        wait_for(1, "timeout_rd");
        repeat (TIMEOUT) @(negedge clk);
        check("timeout_err_before", 32'(bus.fetch_err), 0);
        check("timeout_busy_before", 32'(bus.busy), 1);
        @(negedge clk);
        check("timeout_err", 32'(bus.fetch_err), 1);
        check("timeout_busy", 32'(bus.busy), 0);
        rom_lat = 1;
        r0 = rd_cnt;
        bus.run = 1'b1;
        bus.instr_ready = 1'b1;
        repeat (10) @(negedge clk);
        bus.run = 1'b0;
        pulse_step();
        repeat (10) @(negedge clk);
        check("halt_no_rd", 32'(rd_cnt - r0), 0);
        check("halt_err_sticky", 32'(bus.fetch_err), 1);
        check("halt_busy", 32'(bus.busy), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_clears_err", 32'(bus.fetch_err), 0);
        rst = 1'b0;
        bus.instr_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
